// File: rtl/cdc_handshake_tx_if.sv
// Local producer port and remote req/ack/data port of the
// 4-phase bundled-data crossing launch end.
interface cdc_handshake_tx_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              xfer_req;
   logic [DATA_W-1:0] xfer_data;
   logic              xfer_ack;
   logic              busy;
   logic              done;

   modport slave (
      input  in_valid,
      input  in_data,
      input  xfer_ack,
      output in_ready,
      output xfer_req,
      output xfer_data,
      output busy,
      output done
   );

   modport master (
      output in_valid,
      output in_data,
      output xfer_ack,
      input  in_ready,
      input  xfer_req,
      input  xfer_data,
      input  busy,
      input  done
   );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Launch end of a 4-phase req/ack bundled-data CDC.
// xfer_ack is only ever seen through the local synchronizer chain.
module cdc_handshake_tx #(
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   cdc_handshake_tx_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_REL  = 2'd2;

   logic [1:0]             r_state;
   logic                   r_req;
   logic [DATA_W-1:0]      r_data;
   logic                   r_done;
   logic [SYNC_STAGES-1:0] r_sync;

   logic w_ack_s;
   logic w_ready;
   logic w_accept;

   assign w_ack_s  = r_sync[SYNC_STAGES-1];
   // A stale ack left over from before reset blocks new words
   assign w_ready  = (r_state == S_IDLE) && !w_ack_s;
   assign w_accept = bus.in_valid && w_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_sync  <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.xfer_ack};
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_data  <= bus.in_data;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (w_ack_s) begin
                  r_req   <= 1'b0;
                  r_state <= S_REL;
               end
            end
            S_REL: begin
               if (!w_ack_s) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.xfer_req  = r_req;
   assign bus.xfer_data = r_data;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = r_done;
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx: accepted words are queued,
// a monitor pops them when the request rises and counts done pulses.
module tb_cdc_handshake_tx;
   localparam int DW = 32;
   localparam int SS = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic ack_dir = 1'b0;
   logic ack_rem = 1'b0;
   logic remote_en = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   logic [DW-1:0] exp_q[$];

   cdc_handshake_tx_if #(.DATA_W(DW)) bus ();

   assign bus.in_valid = in_valid;
   assign bus.in_data  = in_data;
   assign bus.xfer_ack = remote_en ? ack_rem : ack_dir;

   cdc_handshake_tx #(
      .DATA_W(DW),
      .SYNC_STAGES(SS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: sampled mid-high-phase, away from both edges
   logic          prev_req = 1'b0;
   logic          prev_done = 1'b0;
   logic [DW-1:0] held = '0;
   always @(posedge clk) begin
      #2;
      if (!rst) begin
         if (bus.xfer_req && !prev_req) begin
            if (exp_q.size() == 0) begin
               chk("req_without_accept", 1, 0);
            end else begin
               chk("xfer_data_order", bus.xfer_data, exp_q.pop_front());
            end
            held = bus.xfer_data;
         end else if (bus.busy) begin
            chk("xfer_data_stable", bus.xfer_data, held);
         end
         if (bus.done) begin
            done_cnt++;
            chk("done_width", prev_done, 0);
         end
         chk("ready_while_busy", bus.in_ready & bus.busy, 0);
      end
      prev_req  = bus.xfer_req;
      prev_done = bus.done;
   end

   // Responsive remote receiver with random latency in both phases
   initial begin
      forever begin
         @(negedge clk);
         if (remote_en && bus.xfer_req && !ack_rem) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ack_rem = 1'b1;
            for (int k = 0; k < 100 && bus.xfer_req; k++)
               @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ack_rem = 1'b0;
         end
      end
   end

   // Called on a negedge; returns on the negedge after the accept edge
   task automatic send(input logic [DW-1:0] w, input int gap);
      int k;
      in_valid = 1'b1;
      in_data  = w;
      k = 0;
      while (!bus.in_ready && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (!bus.in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(w);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      repeat (gap) begin
         @(negedge clk);
         in_data = $urandom;
      end
   endtask

   task automatic wait_done(input int target);
      int k;
      k = 0;
      while (done_cnt < target && k < 400) begin
         @(negedge clk);
         in_data = $urandom;
         k++;
      end
      chk("done_count", done_cnt, target);
   endtask

   task automatic wait_req_low();
      int k;
      k = 0;
      while (bus.xfer_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("req_low_timeout", bus.xfer_req, 0);
   endtask

   initial begin
      int base;
      int k;
      logic [DW-1:0] w;

      repeat (3) @(negedge clk);
      chk("rst_req", bus.xfer_req, 0);
      chk("rst_data", bus.xfer_data, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", bus.in_ready, 1);

      // Single transfer, remote acks 3 cycles after request
      base = done_cnt;
      send(32'hDEADBEEF, 0);
      chk("t1_req_after_accept", bus.xfer_req, 1);
      chk("t1_data", bus.xfer_data, 32'hDEADBEEF);
      repeat (3) @(negedge clk);
      ack_dir = 1'b1;
      k = 0;
      while (bus.xfer_req && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t1_req_fall_latency", k, SS + 1);
      ack_dir = 1'b0;
      wait_done(base + 1);
      chk("t1_ready_back", bus.in_ready, 1);

      // Ack withheld: request held, data frozen despite in_data noise
      base = done_cnt;
      send(32'h0000A5A5, 0);
      for (int i = 0; i < 20; i++) begin
         in_data = $urandom;
         @(negedge clk);
      end
      chk("t2_req_held", bus.xfer_req, 1);
      chk("t2_busy", bus.busy, 1);
      chk("t2_not_ready", bus.in_ready, 0);
      chk("t2_data_held", bus.xfer_data, 32'h0000A5A5);
      chk("t2_no_done", done_cnt, base);
      ack_dir = 1'b1;
      wait_req_low();
      ack_dir = 1'b0;
      wait_done(base + 1);

      // Stale ack pulse while idle
      base = done_cnt;
      ack_dir = 1'b1;
      @(negedge clk);
      ack_dir = 1'b0;
      repeat (6) @(negedge clk);
      chk("t6_req", bus.xfer_req, 0);
      chk("t6_busy", bus.busy, 0);
      chk("t6_no_done", done_cnt, base);
      chk("t6_ready", bus.in_ready, 1);

      // Reset while in REQ with ack high
      base = done_cnt;
      send(32'h12345678, 0);
      ack_dir = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t4_req_drop", bus.xfer_req, 0);
      chk("t4_busy_drop", bus.busy, 0);
      chk("t4_data_clr", bus.xfer_data, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (SS + 1) @(negedge clk);
      chk("t4_stale_ack_block", bus.in_ready, 0);
      ack_dir = 1'b0;
      for (int i = 1; i < SS; i++) begin
         @(negedge clk);
         chk("t4_still_blocked", bus.in_ready, 0);
      end
      @(negedge clk);
      chk("t4_ready_after_sync", bus.in_ready, 1);
      chk("t4_no_done", done_cnt, base);

      // Back-to-back words with a responsive remote
      remote_en = 1'b1;
      base = done_cnt;
      send(32'd1, 0);
      send(32'd2, 0);
      send(32'd3, 0);
      wait_done(base + 3);

      // Randomized traffic
      base = done_cnt;
      for (int i = 0; i < 40; i++) begin
         w = $urandom;
         send(w, $urandom_range(0, 4));
      end
      wait_done(base + 40);
      chk("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
